instr_encoder: RTL and testbench

Streaming RISC-V instruction encoder and instruction-memory loader: the write-side counterpart to the CPU's instruction decode and control path. It accepts symbolic instruction requests (mnemonic + rd/rs1/rs2/imm) over a valid/ready handshake and encodes them into 32-bit RV32IM words for the supported subset (R-type ALU/M-extension, I-type ALU, LUI, CSRRW to the GPIO CSRs 0xF00/0xF02). It buffers the words and writes them sequentially into instruction memory, holding the 3-stage CPU in reset until the program is loaded.

---
 rtl/instr_enc_pkg.sv | 90 +++++++++
 rtl/sync_fifo.sv | 48 ++++
 rtl/instr_encoder.sv | 145 ++++++++++++++
 tb/tb_instr_encoder.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_enc_pkg.sv
// Shared types, RV32IM encoding constants and the symbolic-to-binary
// instruction encoder used by the program loader.
package instr_enc_pkg;

    typedef enum logic [4:0] {
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU,
        ADDI, SLLI, SLTIU, XORI, SRLI, ORI, ANDI,
        LUI, CSRRW_IN, CSRRW_OUT
    } mnem_e;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [11:0] CSR_IO_IN  = 12'hF00;
    localparam logic [11:0] CSR_IO_OUT = 12'hF02;

    typedef struct packed {
        logic        last;
        logic [31:0] word;
    } fifo_ent_t;

    typedef struct packed {
        logic        ok;
        logic [31:0] word;
    } enc_t;

    function automatic logic [31:0] r_word(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, OP_R};
    endfunction

    function automatic logic [31:0] i_word(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic enc_t encode(input logic [4:0] mnem, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [19:0] imm);
        enc_t        e;
        logic [11:0] shamt;
        e.ok   = 1'b1;
        e.word = '0;
        shamt  = {7'b0, imm[4:0]};
        case (mnem)
            ADD:       e.word = r_word(F7_BASE,   3'b000, rd, rs1, rs2);
            SUB:       e.word = r_word(F7_ALT,    3'b000, rd, rs1, rs2);
            SLL:       e.word = r_word(F7_BASE,   3'b001, rd, rs1, rs2);
            SLT:       e.word = r_word(F7_BASE,   3'b010, rd, rs1, rs2);
            SLTU:      e.word = r_word(F7_BASE,   3'b011, rd, rs1, rs2);
            XOR:       e.word = r_word(F7_BASE,   3'b100, rd, rs1, rs2);
            SRL:       e.word = r_word(F7_BASE,   3'b101, rd, rs1, rs2);
            SRA:       e.word = r_word(F7_ALT,    3'b101, rd, rs1, rs2);
            OR:        e.word = r_word(F7_BASE,   3'b110, rd, rs1, rs2);
            AND:       e.word = r_word(F7_BASE,   3'b111, rd, rs1, rs2);
            MUL:       e.word = r_word(F7_MULDIV, 3'b000, rd, rs1, rs2);
            MULH:      e.word = r_word(F7_MULDIV, 3'b001, rd, rs1, rs2);
            MULHSU:    e.word = r_word(F7_MULDIV, 3'b010, rd, rs1, rs2);
            MULHU:     e.word = r_word(F7_MULDIV, 3'b011, rd, rs1, rs2);
            DIV:       e.word = r_word(F7_MULDIV, 3'b100, rd, rs1, rs2);
            DIVU:      e.word = r_word(F7_MULDIV, 3'b101, rd, rs1, rs2);
            REM:       e.word = r_word(F7_MULDIV, 3'b110, rd, rs1, rs2);
            REMU:      e.word = r_word(F7_MULDIV, 3'b111, rd, rs1, rs2);
            ADDI:      e.word = i_word(imm[11:0], rs1, 3'b000, rd, OP_I);
            SLLI:      e.word = i_word(shamt,     rs1, 3'b001, rd, OP_I);
            SLTIU:     e.word = i_word(imm[11:0], rs1, 3'b011, rd, OP_I);
            XORI:      e.word = i_word(imm[11:0], rs1, 3'b100, rd, OP_I);
            SRLI:      e.word = i_word(shamt,     rs1, 3'b101, rd, OP_I);
            ORI:       e.word = i_word(imm[11:0], rs1, 3'b110, rd, OP_I);
            ANDI:      e.word = i_word(imm[11:0], rs1, 3'b111, rd, OP_I);
            LUI:       e.word = {imm, rd, OP_LUI};
            CSRRW_IN:  e.word = i_word(CSR_IO_IN,  rs1, 3'b001, rd, OP_SYS);
            CSRRW_OUT: e.word = i_word(CSR_IO_OUT, rs1, 3'b001, rd, OP_SYS);
            default:   e.ok   = 1'b0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and a synchronous flush.
module sync_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, rptr_q;
    logic         do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_ONE;
            if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wptr_q[AW-1:0]] <= din;
    end

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign dout  = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/instr_encoder.sv
// Encodes symbolic instruction requests into RV32IM words and streams them
// into instruction memory, holding the CPU in reset until the load completes.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_mnem,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [19:0]       req_imm,
    input  logic              req_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err_illegal,
    output logic              err_ovf
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              last_acc_q, last_acc_d;
    logic              err_ill_q, err_ill_d;
    logic              err_ovf_q, err_ovf_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;

    enc_t      enc;
    fifo_ent_t din, dout;
    logic      full, empty, flush, accept, push, pop;

    assign enc = encode(req_mnem, req_rd, req_rs1, req_rs2, req_imm);
    assign din = {req_last, enc.word};

    // cnt_q counts accepted words; refusing once it reaches the address space
    // keeps requests beyond the last writable slot from being taken at all.
    assign req_ready = (state_q == LOAD) && !full && !last_acc_q && !err_ovf_q && !cnt_q[ADDR_W];
    assign accept    = req_valid && req_ready;
    assign push      = accept && enc.ok;
    assign pop       = (state_q == LOAD) && !empty && !err_ovf_q;

    sync_fifo #(.W(33), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        last_acc_d = last_acc_q;
        err_ill_d  = err_ill_q;
        err_ovf_d  = err_ovf_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        flush      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = LOAD;
                    addr_d     = '0;
                    cnt_d      = '0;
                    last_acc_d = 1'b0;
                    err_ill_d  = 1'b0;
                    err_ovf_d  = 1'b0;
                    flush      = 1'b1;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (req_last) last_acc_d = 1'b1;
                    if (enc.ok) cnt_d = cnt_q + (ADDR_W+1)'(1);
                    else        err_ill_d = 1'b1;
                end
                if (pop) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = dout.word;
                    addr_d  = addr_q + ADDR_W'(1);
                    if (&addr_q && !dout.last) err_ovf_d = 1'b1;
                end
                // Leaving one cycle after the final write keeps done/cpu_hold
                // trailing the last imem_we.
                if (err_ovf_q) begin
                    state_d = DONE;
                    flush   = 1'b1;
                end else if (last_acc_q && empty) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            last_acc_q <= 1'b0;
            err_ill_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            last_acc_q <= last_acc_d;
            err_ill_q  <= err_ill_d;
            err_ovf_q  <= err_ovf_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign imem_we     = we_q;
    assign imem_addr   = waddr_q;
    assign imem_wdata  = wdata_q;
    assign cpu_hold    = (state_q != DONE);
    assign done        = (state_q == DONE);
    assign err_illegal = err_ill_q;
    assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed and random programs
// compared against a field-level RV32IM encoding model.
module tb_instr_encoder;
    import instr_enc_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 12;

    typedef struct {
        int m, rd, rs1, rs2, imm;
        bit last;
    } req_t;

    logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic              req_valid = 1'b0, req_last = 1'b0;
    logic [4:0]        req_mnem = '0, req_rd = '0, req_rs1 = '0, req_rs2 = '0;
    logic [19:0]       req_imm = '0;
    logic              req_ready, imem_we, cpu_hold, done, err_illegal, err_ovf;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    int checks = 0, errors = 0, cyc = 0;
    int acc_span = 0;
    logic [ADDR_W-1:0] w_addr[$];
    logic [31:0]       w_data[$];
    int                w_cyc[$];
    req_t              prog[$];

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .req_valid(req_valid), .req_ready(req_ready), .req_mnem(req_mnem),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .req_last(req_last), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done),
        .err_illegal(err_illegal), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            w_addr.push_back(imem_addr);
            w_data.push_back(imem_wdata);
            w_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (got no finish, want finish)");
        $fatal(1, "watchdog");
    end

    // Reference: assemble the word from the ISA fields with plain arithmetic.
    function automatic bit ref_enc(input req_t r, output logic [31:0] w);
        int r_f3[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
        int i_f3[7]  = '{0, 1, 3, 4, 5, 6, 7};
        int f3, f7, hi;
        w = '0;
        if (r.m <= int'(REMU)) begin
            if (r.m >= int'(MUL)) begin
                f7 = 1; f3 = r.m - int'(MUL);
            end else begin
                f3 = r_f3[r.m];
                f7 = (r.m == int'(SUB) || r.m == int'(SRA)) ? 32 : 0;
            end
            w = (f7 << 25) | (r.rs2 << 20) | (r.rs1 << 15) | (f3 << 12) | (r.rd << 7) | 'h33;
        end else if (r.m <= int'(ANDI)) begin
            hi = (r.m == int'(SLLI) || r.m == int'(SRLI)) ? (r.imm & 'h1F) : (r.imm & 'hFFF);
            w = (hi << 20) | (r.rs1 << 15) | (i_f3[r.m - int'(ADDI)] << 12) | (r.rd << 7) | 'h13;
        end else if (r.m == int'(LUI)) begin
            w = ((r.imm & 'hFFFFF) << 12) | (r.rd << 7) | 'h37;
        end else if (r.m == int'(CSRRW_IN) || r.m == int'(CSRRW_OUT)) begin
            hi = (r.m == int'(CSRRW_IN)) ? 'hF00 : 'hF02;
            w = (hi << 20) | (r.rs1 << 15) | (1 << 12) | (r.rd << 7) | 'h73;
        end else begin
            return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic req_t mk(input int m, input int rd, input int rs1, input int rs2,
                                input int imm, input bit last);
        req_t r;
        r.m = m; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm; r.last = last;
        return r;
    endfunction

    function automatic req_t rand_req(input bit last);
        req_t r;
        r.m    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(28, 31)) : int'($urandom_range(0, 27));
        r.rd   = $urandom_range(0, 31);
        r.rs1  = $urandom_range(0, 31);
        r.rs2  = $urandom_range(0, 31);
        r.imm  = $urandom_range(0, 20'hFFFFF);
        r.last = last;
        return r;
    endfunction

    task automatic drive(input req_t r, input bit v);
        req_valid = v;
        req_mnem  = 5'(r.m);
        req_rd    = 5'(r.rd);
        req_rs1   = 5'(r.rs1);
        req_rs2   = 5'(r.rs2);
        req_imm   = 20'(r.imm);
        req_last  = r.last;
    endtask

    task automatic send(input req_t r, output bit ok);
        ok = 1'b0;
        drive(r, 1'b1);
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        req_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send: request not accepted in 50 cycles (got ready=0, want 1)");
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_prog(input string name, input int max_gap);
        logic [31:0] exp_w[$];
        logic [31:0] w;
        bit ill = 1'b0, ok, bad_rdy = 1'b0, got_done = 1'b0, last_legal;
        int acc_first = 0, acc_last = 0, dcyc = 0;
        foreach (prog[i]) begin
            if (ref_enc(prog[i], w)) exp_w.push_back(w);
            else ill = 1'b1;
        end
        last_legal = ref_enc(prog[prog.size()-1], w);
        w_addr.delete(); w_data.delete(); w_cyc.delete();
        pulse_start();
        foreach (prog[i]) begin
            send(prog[i], ok);
            if (i == 0) acc_first = cyc;
            acc_last = cyc;
            if (!prog[i].last && max_gap > 0)
                repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
        end
        acc_span = acc_last - acc_first;
        for (int k = 0; k < 100 && !got_done; k++) begin
            @(negedge clk);
            if (done) begin got_done = 1'b1; dcyc = cyc; end
            else if (req_ready) bad_rdy = 1'b1;
        end
        checks++;
        if (!got_done) begin errors++; $display("FAIL %s done: got 0, want 1", name); end
        checks++;
        if (bad_rdy) begin errors++; $display("FAIL %s ready_after_last: got 1, want 0", name); end
        checks++;
        if (w_data.size() != exp_w.size()) begin
            errors++;
            $display("FAIL %s write_count: got %0d, want %0d", name, w_data.size(), exp_w.size());
        end
        foreach (exp_w[i]) begin
            if (i < w_data.size()) begin
                checks++;
                if (w_data[i] !== exp_w[i] || w_addr[i] !== ADDR_W'(i)) begin
                    errors++;
                    $display("FAIL %s word[%0d]: got addr=%0d data=%08h, want addr=%0d data=%08h",
                             name, i, w_addr[i], w_data[i], i, exp_w[i]);
                end
            end
        end
        checks++;
        if (err_illegal !== ill) begin
            errors++; $display("FAIL %s err_illegal: got %b, want %b", name, err_illegal, ill);
        end
        checks++;
        if (err_ovf !== 1'b0 || cpu_hold !== 1'b0) begin
            errors++; $display("FAIL %s ovf/hold: got %b/%b, want 0/0", name, err_ovf, cpu_hold);
        end
        if (got_done && last_legal && w_cyc.size() > 0) begin
            checks++;
            if (dcyc != w_cyc[w_cyc.size()-1] + 1) begin
                errors++;
                $display("FAIL %s done_timing: got cycle %0d, want %0d", name, dcyc, w_cyc[w_cyc.size()-1] + 1);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({imem_we, imem_addr, imem_wdata} !== '0) begin
            errors++; $display("FAIL reset imem: got we=%b addr=%0d data=%08h, want 0/0/0", imem_we, imem_addr, imem_wdata);
        end
        checks++;
        if ({req_ready, cpu_hold, done} !== 3'b010) begin
            errors++; $display("FAIL reset ctl: got ready/hold/done=%b%b%b, want 010", req_ready, cpu_hold, done);
        end
        checks++;
        if ({err_illegal, err_ovf} !== 2'b00) begin
            errors++; $display("FAIL reset errs: got %b%b, want 00", err_illegal, err_ovf);
        end
    endtask

    task automatic test_single_add();
        prog.delete();
        prog.push_back(mk(int'(ADD), 3, 1, 2, 0, 1'b1));
        check_prog("add", 0);
        checks++;
        if (w_data.size() != 1 || w_data[0] !== 32'h002081B3) begin
            errors++; $display("FAIL add_const: got %08h, want 002081b3", (w_data.size() > 0) ? w_data[0] : 32'h0);
        end
    endtask

    task automatic test_sequence();
        logic [31:0] kv[4] = '{32'h402081B3, 32'h00500093, 32'h123452B7, 32'hF00010F3};
        prog.delete();
        prog.push_back(mk(int'(SUB), 3, 1, 2, 0, 1'b0));
        prog.push_back(mk(int'(ADDI), 1, 0, 0, 5, 1'b0));
        prog.push_back(mk(int'(LUI), 5, 0, 0, 'h12345, 1'b0));
        prog.push_back(mk(int'(CSRRW_IN), 1, 0, 0, 0, 1'b1));
        check_prog("seq", 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= w_data.size() || w_data[i] !== kv[i]) begin
                errors++;
                $display("FAIL seq_const[%0d]: got %08h, want %08h", i, (i < w_data.size()) ? w_data[i] : 32'h0, kv[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        prog.delete();
        for (int i = 0; i < 6; i++)
            prog.push_back(mk(int'(MUL), $urandom_range(0, 31), $urandom_range(0, 31),
                              $urandom_range(0, 31), 0, i == 5));
        check_prog("b2b", 0);
        checks++;
        if (acc_span != 5) begin errors++; $display("FAIL b2b accept_span: got %0d, want 5", acc_span); end
        checks++;
        if (w_cyc.size() != 6 || w_cyc[5] - w_cyc[0] != 5) begin
            errors++; $display("FAIL b2b write_span: got %0d writes, want 6 in 6 consecutive cycles", w_cyc.size());
        end
    endtask

    task automatic test_illegal();
        prog.delete();
        prog.push_back(mk(int'(ADDI), 1, 0, 0, 5, 1'b0));
        prog.push_back(mk(31, 2, 3, 4, 0, 1'b0));
        prog.push_back(mk(int'(ADDI), 2, 1, 0, 7, 1'b1));
        check_prog("illegal_mid", 0);
        prog.delete();
        prog.push_back(mk(int'(XORI), 4, 2, 0, 'hABC, 1'b0));
        prog.push_back(mk(30, 0, 0, 0, 0, 1'b1));
        check_prog("illegal_last", 3);
    endtask

    task automatic test_random();
        int n;
        for (int p = 0; p < 20; p++) begin
            prog.delete();
            n = $urandom_range(1, 8);
            for (int j = 0; j < n; j++) prog.push_back(rand_req(j == n - 1));
            check_prog("rand", 2);
        end
    endtask

    task automatic test_overflow();
        req_t r;
        logic [31:0] exp_w[$];
        logic [31:0] w;
        bit ok, got_done = 1'b0;
        int rdy_seen = 0;
        w_addr.delete(); w_data.delete(); w_cyc.delete();
        pulse_start();
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            r = rand_req(1'b0);
            r.m = $urandom_range(0, 27);
            void'(ref_enc(r, w));
            exp_w.push_back(w);
            send(r, ok);
        end
        drive(mk(int'(ADD), 1, 2, 3, 0, 1'b0), 1'b1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready) rdy_seen++;
            if (done) got_done = 1'b1;
        end
        req_valid = 1'b0;
        checks++;
        if (rdy_seen != 0) begin errors++; $display("FAIL ovf refuse: got ready %0d cycles, want 0", rdy_seen); end
        checks++;
        if (!got_done || err_ovf !== 1'b1) begin
            errors++; $display("FAIL ovf flags: got done=%b err_ovf=%b, want 1/1", got_done, err_ovf);
        end
        checks++;
        if (w_data.size() != (1 << ADDR_W)) begin
            errors++; $display("FAIL ovf write_count: got %0d, want %0d", w_data.size(), 1 << ADDR_W);
        end
        foreach (exp_w[i]) begin
            if (i < w_data.size()) begin
                checks++;
                if (w_data[i] !== exp_w[i] || w_addr[i] !== ADDR_W'(i)) begin
                    errors++;
                    $display("FAIL ovf word[%0d]: got addr=%0d data=%08h, want addr=%0d data=%08h",
                             i, w_addr[i], w_data[i], i, exp_w[i]);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midload();
        bit ok;
        w_addr.delete(); w_data.delete(); w_cyc.delete();
        pulse_start();
        for (int i = 0; i < 3; i++) send(mk(int'(ADDI), i + 1, 0, 0, i, 1'b0), ok);
        for (int k = 0; k < 20 && w_data.size() < 2; k++) @(negedge clk);
        checks++;
        if (w_data.size() < 2) begin errors++; $display("FAIL midload writes: got %0d, want 2", w_data.size()); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_we, imem_addr, imem_wdata} !== '0) begin
            errors++; $display("FAIL midload imem: got we=%b addr=%0d data=%08h, want 0/0/0", imem_we, imem_addr, imem_wdata);
        end
        checks++;
        if ({req_ready, cpu_hold, done, err_illegal, err_ovf} !== 5'b01000) begin
            errors++; $display("FAIL midload ctl: got %b%b%b%b%b, want 01000", req_ready, cpu_hold, done, err_illegal, err_ovf);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        prog.delete();
        prog.push_back(mk(int'(ADD), 7, 4, 5, 0, 1'b1));
        check_prog("reload", 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_single_add();
        test_sequence();
        test_back_to_back();
        test_illegal();
        test_random();
        test_overflow();
        test_reset_midload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
